// File: rtl/div_unit.sv
// div_unit: sequential radix-2 restoring divider (DIV/DIVU) returning quotient (LO) and remainder (HI).
module div_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  cancel,
  input  logic                  isSigned,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  divByZero
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]    state, state_d;
  logic          sgn_r, sgn_d;
  logic          sa_r, sa_d;
  logic          sb_r, sb_d;
  logic          zero_r, zero_d;
  logic [W-1:0]  aorig_r, aorig_d;
  logic [W-1:0]  bmag_r, bmag_d;
  logic [W-1:0]  rem_r, rem_d;
  logic [W-1:0]  q_r, q_d;
  logic [CW-1:0] cnt_r, cnt_d;
  logic          busy_d, done_d, dbz_d;
  logic [W-1:0]  quo_d, remo_d;

  // restoring step datapath
  logic [W:0]    rem_sh;
  logic [W:0]    trial;
  logic          ge;
  logic [W-1:0]  amag, bmagn;

  assign amag   = (isSigned && A[W-1]) ? (W'(0) - A) : A;
  assign bmagn  = (isSigned && B[W-1]) ? (W'(0) - B) : B;
  assign rem_sh = {rem_r, q_r[W-1]};
  assign trial  = rem_sh - {1'b0, bmag_r};
  assign ge     = ~trial[W];

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // next-state, working-register and output computation
  always_comb begin
    state_d = state;
    sgn_d   = sgn_r;
    sa_d    = sa_r;
    sb_d    = sb_r;
    zero_d  = zero_r;
    aorig_d = aorig_r;
    bmag_d  = bmag_r;
    rem_d   = rem_r;
    q_d     = q_r;
    cnt_d   = cnt_r;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    quo_d   = quotient;
    remo_d  = remainder;
    dbz_d   = divByZero;
    case (state)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          sgn_d   = isSigned;
          sa_d    = isSigned & A[W-1];
          sb_d    = isSigned & B[W-1];
          zero_d  = (B == W'(0));
          aorig_d = A;
          bmag_d  = bmagn;
          busy_d  = 1'b1;
          if (B == W'(0)) begin
            state_d = ST_FIX;
          end else begin
            rem_d   = W'(0);
            q_d     = amag;
            cnt_d   = CW'(0);
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else begin
          rem_d  = ge ? trial[W-1:0] : rem_sh[W-1:0];
          q_d    = {q_r[W-2:0], ge};
          cnt_d  = cnt_r + CW'(1);
          busy_d = 1'b1;
          if (cnt_r == CW'(DATA_WIDTH - 1)) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        if (cancel) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          if (zero_r) begin
            quo_d  = '1;
            remo_d = aorig_r;
            dbz_d  = 1'b1;
          end else begin
            quo_d  = (sgn_r && (sa_r != sb_r)) ? (W'(0) - q_r) : q_r;
            remo_d = sa_r ? (W'(0) - rem_r) : rem_r;
            dbz_d  = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // working registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn_r     <= 1'b0;
      sa_r      <= 1'b0;
      sb_r      <= 1'b0;
      zero_r    <= 1'b0;
      aorig_r   <= '0;
      bmag_r    <= '0;
      rem_r     <= '0;
      q_r       <= '0;
      cnt_r     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      divByZero <= 1'b0;
    end else begin
      sgn_r     <= sgn_d;
      sa_r      <= sa_d;
      sb_r      <= sb_d;
      zero_r    <= zero_d;
      aorig_r   <= aorig_d;
      bmag_r    <= bmag_d;
      rem_r     <= rem_d;
      q_r       <= q_d;
      cnt_r     <= cnt_d;
      busy      <= busy_d;
      done      <= done_d;
      quotient  <= quo_d;
      remainder <= remo_d;
      divByZero <= dbz_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed-vector bench for div_unit at the default 32-bit width.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, cancel, is_signed;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int total = 0;
  int bad   = 0;

  div_unit #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cancel    (cancel),
    .isSigned  (is_signed),
    .A         (a),
    .B         (b),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .divByZero (div_by_zero)
  );

  always #5 clk = ~clk;

  // single comparison point
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // launch at the current negedge (cycle 0); returns at the negedge of the done cycle
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] eq, input logic [31:0] er, input logic edbz, input int elat,
                        input int ign_cyc);
    int lat;
    int busy_bad;
    lat = 0;
    busy_bad = 0;
    start = 1'b1; is_signed = sgn; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (done) begin
        lat = k;
        if (busy) busy_bad++;
        break;
      end
      if (!busy) busy_bad++;
      if (k == ign_cyc) begin
        start = 1'b1; is_signed = ~sgn; a = 32'd50; b = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, ".lat"}, 32'(lat), 32'(elat));
    chk({tag, ".busy"}, 32'(busy_bad), 32'd0);
    chk({tag, ".q"}, quotient, eq);
    chk({tag, ".r"}, remainder, er);
    chk({tag, ".dbz"}, 32'(div_by_zero), 32'(edbz));
  endtask

  initial begin
    int dcount;
    rst_n = 1'b0; start = 1'b0; cancel = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    #12;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.q", quotient, 32'd0);
    chk("rst.r", remainder, 32'd0);
    chk("rst.dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    do_div("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 0);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);

    do_div("sm7_2",  1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 0);
    @(negedge clk);
    do_div("s7_m2",  1'b1, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        1'b0, 34, 0);
    @(negedge clk);
    do_div("sm7_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,       32'hFFFF_FFFF, 1'b0, 34, 0);
    @(negedge clk);
    do_div("s_ovf",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,       1'b0, 34, 0);
    @(negedge clk);
    do_div("u_max1", 1'b0, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 32'd0,        1'b0, 34, 0);
    @(negedge clk);
    do_div("u5_9",   1'b0, 32'd5,        32'd9,         32'd0,        32'd5,         1'b0, 34, 0);
    @(negedge clk);
    do_div("dbz",    1'b0, 32'h1234_5678, 32'd0,        32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 2, 0);
    @(negedge clk);
    do_div("u10_5",  1'b0, 32'd10,       32'd5,         32'd2,        32'd0,         1'b0, 34, 0);
    @(negedge clk);

    // start during busy (cycle 10) must be ignored
    do_div("ign",    1'b0, 32'd100,      32'd7,         32'd14,       32'd2,         1'b0, 34, 10);
    // start in the done cycle is accepted
    do_div("b2b",    1'b0, 32'd20,       32'd6,         32'd3,        32'd2,         1'b0, 34, 0);
    @(negedge clk);

    // cancel in cycle 20: no done, outputs held from the 20/6 result
    start = 1'b1; is_signed = 1'b0; a = 32'd1000; b = 32'd10;
    dcount = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start = 1'b0;
      cancel = (k == 20);
      if (done) dcount++;
      if (k == 25) chk("cancel.busy", 32'(busy), 32'd0);
    end
    cancel = 1'b0;
    chk("cancel.done", 32'(dcount), 32'd0);
    chk("cancel.q", quotient, 32'd3);
    chk("cancel.r", remainder, 32'd2);
    @(negedge clk);

    // async reset in cycle 15 of an operation
    start = 1'b1; is_signed = 1'b0; a = 32'd100; b = 32'd7;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.done", 32'(done), 32'd0);
    chk("arst.q", quotient, 32'd0);
    chk("arst.r", remainder, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    do_div("post_rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
